mem_seq: RTL and testbench
==========================

# mem_seq

Front-end command sequencer for the on-board SRAM test path. Turns three raw push-buttons (write, read, next-address) into clean, single-shot, correctly timed SRAM access strobes, and owns the low address bits and the latched write byte. It sits directly upstream of the memory stage, which routes the strobes and address to the SRAM pins and the read byte to the 7-segment transcoders. Strobes are active-low, so they can drive the SRAM control pins unchanged.

## Interface
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
- STROBE_CYCLES, 4, width of the rd/wr strobe low pulse in clk cycles; legal range ≥1.
- ADDR_W, 3, width of the address counter.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- btn_wr  in  1  raw write button, active-high, asynchronous.
- btn_rd  in  1  raw read button, active-high, asynchronous.
- btn_nxt  in  1  raw next-address button, active-high, asynchronous.
- data_sw  in  8  write data switches, sampled on write acceptance.
- wr_enable  out  1  SRAM write strobe, active-low.
- rd_enable  out  1  SRAM read/output-enable strobe, active-low.
- addr  out  ADDR_W  current SRAM address.
- data_out  out  8  latched write byte, presented to the memory stage.
- busy  out  1  high while an access is in progress.

## Operation
- Per button:
  - A 2-FF synchronizer feeds a debouncer.
  - The debounced level takes the synchronized value after it has differed from the debounced value for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle reloads the counter.
  - A rising edge of the debounced level produces a one-cycle event (ev_wr, ev_rd, ev_nxt). Release produces no event.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: busy=0, both strobes high. Events are taken with priority wr > rd > nxt; events that lose arbitration are discarded.
    - ev_wr: latch data_sw into data_out, record op=WR, go to SETUP.
    - ev_rd: record op=RD, go to SETUP.
    - ev_nxt: addr <= addr+1 (mod 2^ADDR_W), stay in IDLE.
  - SETUP: one cycle; addr and data_out stable, strobes high; go to STROBE.
  - STROBE: op's strobe low for exactly STROBE_CYCLES cycles (down-counter); the other strobe stays high; go to HOLD.
  - HOLD: one cycle; strobes high, addr held. On exit: if op=WR, addr <= addr+1 (mod 2^ADDR_W); if op=RD, addr unchanged. Go to IDLE.
- busy=1 in SETUP, STROBE and HOLD. Any event arriving while busy=1 is dropped, not queued.
- wr_enable and rd_enable are never low in the same cycle. Both are registered outputs, glitch-free.
- Address wrap: addr at 2^ADDR_W-1 advances to 0. No flag.
- data_out changes only on write acceptance; a read never modifies it.

## Timing
- Reset (rst_n low at a rising edge):
  - wr_enable=1, rd_enable=1, addr=0, data_out=0x00, busy=0, state=IDLE.
  - Debounced levels and counters are cleared to 0.
  - A button held through reset deassertion produces an event after debounce, as a fresh press.
- Reset mid-access: strobe returns high at that same edge; addr is not incremented.
- Event in cycle E:
  - SETUP in cycle E+1.
  - Strobe low in cycles E+2 … E+1+STROBE_CYCLES.
  - HOLD in cycle E+2+STROBE_CYCLES.
  - IDLE, with write increment visible, in cycle E+3+STROBE_CYCLES.
  - Total busy = STROBE_CYCLES+2 cycles.
- Raw press to event: DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3 cycles.
- ev_nxt in cycle E: new addr visible in cycle E+1.

## Test plan
- DEBOUNCE_CYCLES=4, STROBE_CYCLES=2, ADDR_W=3 for all scenarios.
- Reset: hold rst_n=0 for 3 cycles with buttons toggling -> wr_enable=1, rd_enable=1, addr=0, data_out=0x00, busy=0 throughout and after.
- Write: data_sw=0xA5, press btn_wr for 20 cycles -> data_out=0xA5; one SETUP cycle; wr_enable low exactly 2 cycles; rd_enable stays high; addr 0 during the access, then 1; busy high exactly 4 cycles; exactly one write despite the long press.
- Read and wrap: starting from addr=0, press btn_nxt 7 times (addr reaches 7), then press btn_rd -> rd_enable low 2 cycles at addr=7, addr stays 7, data_out unchanged. One more btn_nxt -> addr=0.
- Bounce: toggle btn_wr every 2 cycles for 20 cycles, then release -> no event, wr_enable never low, addr unchanged.
- Simultaneous and busy events: btn_wr and btn_rd pressed in the same cycle -> write only. A btn_nxt event landing during STROBE -> dropped, and addr after HOLD = start+1.
- Reset mid-strobe: assert rst_n=0 in the first wr_enable-low cycle -> wr_enable=1 at the next edge, addr=0, state IDLE, no further strobe.

Source files
------------

// File: rtl/mem_seq_if.sv
// Bundle between the push-button front end and the SRAM memory stage.
// master = the sequencer, slave = whatever drives the buttons and consumes the strobes.
interface mem_seq_if #(
  parameter int ADDR_W = 3
);
  logic              btn_wr;
  logic              btn_rd;
  logic              btn_nxt;
  logic [7:0]        data_sw;
  logic              wr_enable;
  logic              rd_enable;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_out;
  logic              busy;

  modport master (
    input  btn_wr, btn_rd, btn_nxt, data_sw,
    output wr_enable, rd_enable, addr, data_out, busy
  );

  modport slave (
    output btn_wr, btn_rd, btn_nxt, data_sw,
    input  wr_enable, rd_enable, addr, data_out, busy
  );
endinterface

// File: rtl/mem_seq.sv
// SRAM command sequencer: debounces three buttons and turns each accepted press
// into one correctly timed active-low read or write strobe.
module mem_seq #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STROBE_CYCLES   = 4,
  parameter int ADDR_W          = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  logic [2:0]        btn_raw;
  logic [2:0]        sync1_q, sync2_q, level_q, level_prev_q;
  logic [DW-1:0]     db_cnt_q [3];
  logic [2:0]        ev;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;

  assign btn_raw = {bus.btn_nxt, bus.btn_rd, bus.btn_wr};

  // Level only flips after an unbroken run of mismatching samples; any agreeing cycle restarts the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            level_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign ev = level_q & ~level_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b1;
      rd_en_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

  // Strobes and busy are derived from the next state so the registered outputs line up with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (ev[0]) begin
          data_d  = bus.data_sw;
          op_wr_d = 1'b1;
          state_d = SETUP;
        end else if (ev[1]) begin
          op_wr_d = 1'b0;
          state_d = SETUP;
        end else if (ev[2]) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      SETUP: begin
        cnt_d   = SW'(STROBE_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - SW'(1);
      end
      HOLD: begin
        if (op_wr_q) addr_d = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    wr_en_d = !((state_d == STROBE) && op_wr_d);
    rd_en_d = !((state_d == STROBE) && !op_wr_d);
  end

  assign bus.wr_enable = wr_en_q;
  assign bus.rd_enable = rd_en_q;
  assign bus.addr      = addr_q;
  assign bus.data_out  = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboarded bench for mem_seq: expected accesses are queued as buttons are pressed
// and matched against every strobe pulse the monitor sees.
module tb_mem_seq;

  typedef struct {
    bit         is_wr;
    logic [2:0] addr;
    logic [7:0] data;
    int         width;
    int         lead;
  } access_t;

  logic clk = 1'b0;
  logic rst_n;

  access_t exp_q[$];
  int      busy_q[$];
  int      compared = 0;
  int      mismatched = 0;
  int      both_low_cycles = 0;
  logic [2:0] model_addr = '0;
  logic [7:0] model_data = '0;

  mem_seq_if #(.ADDR_W(3)) bus ();

  mem_seq #(
    .DEBOUNCE_CYCLES(4),
    .STROBE_CYCLES(2),
    .ADDR_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Monitor: measures each strobe pulse and checks it against the head of the scoreboard.
  access_t wr_rec, rd_rec;
  bit      in_wr = 0, in_rd = 0;
  int      busy_run = 0;
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      busy_q.push_back(busy_run);
      busy_run = 0;
    end
    if (bus.wr_enable === 1'b0 && bus.rd_enable === 1'b0) both_low_cycles++;
    for (int k = 0; k < 2; k++) begin
      logic    low;
      bit      active;
      access_t rec;
      low    = (k == 0) ? (bus.wr_enable === 1'b0) : (bus.rd_enable === 1'b0);
      active = (k == 0) ? in_wr : in_rd;
      rec    = (k == 0) ? wr_rec : rd_rec;
      if (low) begin
        if (!active) begin
          active     = 1;
          rec.is_wr  = (k == 0);
          rec.addr   = bus.addr;
          rec.data   = bus.data_out;
          rec.width  = 0;
          rec.lead   = busy_run - 1;
        end
        rec.width++;
      end else if (active) begin
        active = 0;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL access_unexpected: got wr=%0d addr=%0d data=%02h width=%0d, required no access",
                   rec.is_wr, rec.addr, rec.data, rec.width);
        end else begin
          access_t e;
          e = exp_q.pop_front();
          if (rec.is_wr !== e.is_wr || rec.addr !== e.addr || rec.data !== e.data ||
              rec.width !== e.width || rec.lead !== e.lead) begin
            mismatched++;
            $display("[TB] FAIL access: got wr=%0d addr=%0d data=%02h width=%0d lead=%0d, required wr=%0d addr=%0d data=%02h width=%0d lead=%0d",
                     rec.is_wr, rec.addr, rec.data, rec.width, rec.lead,
                     e.is_wr, e.addr, e.data, e.width, e.lead);
          end
        end
      end
      if (k == 0) begin in_wr = active; wr_rec = rec; end
      else        begin in_rd = active; rd_rec = rec; end
    end
  end

  task automatic expect_access(input bit is_wr, input logic [7:0] data, input int width);
    access_t e;
    e.is_wr = is_wr;
    e.addr  = model_addr;
    e.data  = data;
    e.width = width;
    e.lead  = 1;
    exp_q.push_back(e);
  endtask

  task automatic press_button(input logic w, input logic r, input logic n, input int hold);
    @(negedge clk);
    bus.btn_wr  = w;
    bus.btn_rd  = r;
    bus.btn_nxt = n;
    repeat (hold) @(negedge clk);
    bus.btn_wr  = 1'b0;
    bus.btn_rd  = 1'b0;
    bus.btn_nxt = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_addr = '0;
    model_data = '0;
    busy_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.btn_wr  = 1'b0;
    bus.btn_rd  = 1'b0;
    bus.btn_nxt = 1'b0;
    bus.data_sw = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 3) begin
        bus.btn_wr = 1'b0; bus.btn_rd = 1'b0; bus.btn_nxt = 1'b0;
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
      end
      compared += 5;
      if (bus.wr_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_wr_enable[%0d]: got %b required 1", i, bus.wr_enable); end
      if (bus.rd_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rd_enable[%0d]: got %b required 1", i, bus.rd_enable); end
      if (bus.addr !== 3'd0)      begin mismatched++; $display("[TB] FAIL reset_addr[%0d]: got %0d required 0", i, bus.addr); end
      if (bus.data_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data_out[%0d]: got %02h required 00", i, bus.data_out); end
      if (bus.busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_busy[%0d]: got %b required 0", i, bus.busy); end
      bus.btn_wr  = ~bus.btn_wr;
      bus.btn_rd  = ~bus.btn_rd;
      bus.btn_nxt = ~bus.btn_nxt;
    end
    busy_q.delete();
  endtask

  task automatic test_write();
    bus.data_sw = 8'hA5;
    expect_access(1'b1, 8'hA5, 2);
    press_button(1'b1, 1'b0, 1'b0, 20);
    model_addr++;
    model_data = 8'hA5;
    compared += 4;
    if (bus.data_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL write_data_out: got %02h required a5", bus.data_out); end
    if (bus.addr !== 3'd1)      begin mismatched++; $display("[TB] FAIL write_addr: got %0d required 1", bus.addr); end
    if (exp_q.size() != 0)      begin mismatched++; $display("[TB] FAIL write_count: got %0d pending required 0", exp_q.size()); end
    if (busy_q.size() != 1 || busy_q[0] != 4) begin
      mismatched++;
      $display("[TB] FAIL write_busy_len: got %0d runs first=%0d required 1 run of 4",
               busy_q.size(), (busy_q.size() > 0) ? busy_q[0] : -1);
    end
    busy_q.delete();
  endtask

  task automatic test_read_wrap();
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      press_button(1'b0, 1'b0, 1'b1, 10);
      model_addr++;
    end
    compared++;
    if (bus.addr !== 3'd7) begin mismatched++; $display("[TB] FAIL nxt_addr: got %0d required 7", bus.addr); end
    bus.data_sw = 8'h3C;
    expect_access(1'b0, model_data, 2);
    press_button(1'b0, 1'b1, 1'b0, 20);
    compared += 3;
    if (bus.addr !== 3'd7)      begin mismatched++; $display("[TB] FAIL read_addr: got %0d required 7", bus.addr); end
    if (bus.data_out !== 8'h00) begin mismatched++; $display("[TB] FAIL read_data_out: got %02h required 00", bus.data_out); end
    if (exp_q.size() != 0)      begin mismatched++; $display("[TB] FAIL read_count: got %0d pending required 0", exp_q.size()); end
    press_button(1'b0, 1'b0, 1'b1, 10);
    model_addr++;
    compared++;
    if (bus.addr !== model_addr) begin mismatched++; $display("[TB] FAIL wrap_addr: got %0d required %0d", bus.addr, model_addr); end
    busy_q.delete();
  endtask

  task automatic test_bounce();
    logic [2:0] start_addr;
    start_addr = bus.addr;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.btn_wr = ~bus.btn_wr;
      repeat (2) @(negedge clk);
    end
    bus.btn_wr = 1'b0;
    repeat (15) @(negedge clk);
    compared += 2;
    if (bus.addr !== start_addr) begin mismatched++; $display("[TB] FAIL bounce_addr: got %0d required %0d", bus.addr, start_addr); end
    if (busy_q.size() != 0)      begin mismatched++; $display("[TB] FAIL bounce_busy: got %0d accesses required 0", busy_q.size()); end
  endtask

  task automatic test_simultaneous();
    bus.data_sw = 8'h5A;
    expect_access(1'b1, 8'h5A, 2);
    press_button(1'b1, 1'b1, 1'b0, 20);
    model_addr++;
    model_data = 8'h5A;
    compared += 3;
    if (bus.addr !== model_addr) begin mismatched++; $display("[TB] FAIL simul_addr: got %0d required %0d", bus.addr, model_addr); end
    if (bus.data_out !== 8'h5A)  begin mismatched++; $display("[TB] FAIL simul_data_out: got %02h required 5a", bus.data_out); end
    if (busy_q.size() != 1)      begin mismatched++; $display("[TB] FAIL simul_access_count: got %0d required 1", busy_q.size()); end
    busy_q.delete();
  endtask

  task automatic test_busy_drop();
    logic [2:0] start_addr;
    start_addr  = model_addr;
    bus.data_sw = 8'hC3;
    expect_access(1'b1, 8'hC3, 2);
    @(negedge clk);
    bus.btn_wr = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_nxt = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_wr  = 1'b0;
    bus.btn_nxt = 1'b0;
    repeat (14) @(negedge clk);
    model_addr++;
    model_data = 8'hC3;
    compared += 2;
    if (bus.addr !== start_addr + 3'd1) begin mismatched++; $display("[TB] FAIL drop_addr: got %0d required %0d", bus.addr, start_addr + 3'd1); end
    if (busy_q.size() != 1 || busy_q[0] != 4) begin
      mismatched++;
      $display("[TB] FAIL drop_busy_len: got %0d runs required 1 run of 4", busy_q.size());
    end
    busy_q.delete();
  endtask

  task automatic test_reset_mid_strobe();
    bit seen = 0;
    bus.data_sw = 8'h77;
    expect_access(1'b1, 8'h77, 1);
    @(negedge clk);
    bus.btn_wr = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.wr_enable === 1'b0) seen = 1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL midrst_strobe_timeout: got no strobe within 40 cycles, required one");
    end
    rst_n = 1'b0;
    bus.btn_wr = 1'b0;
    @(negedge clk);
    compared += 4;
    if (bus.wr_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_wr_enable: got %b required 1", bus.wr_enable); end
    if (bus.addr !== 3'd0)      begin mismatched++; $display("[TB] FAIL midrst_addr: got %0d required 0", bus.addr); end
    if (bus.busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL midrst_busy: got %b required 0", bus.busy); end
    if (bus.data_out !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_data_out: got %02h required 00", bus.data_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_addr = '0;
    model_data = '0;
    busy_q.delete();
    repeat (20) @(negedge clk);
    compared += 2;
    if (busy_q.size() != 0)     begin mismatched++; $display("[TB] FAIL midrst_no_restrobe: got %0d accesses required 0", busy_q.size()); end
    if (bus.addr !== 3'd0)      begin mismatched++; $display("[TB] FAIL midrst_addr_after: got %0d required 0", bus.addr); end
  endtask

  task automatic test_exclusive();
    compared += 2;
    if (both_low_cycles != 0) begin mismatched++; $display("[TB] FAIL both_strobes_low: got %0d cycles required 0", both_low_cycles); end
    if (exp_q.size() != 0)    begin mismatched++; $display("[TB] FAIL scoreboard_drain: got %0d unseen accesses required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_bounce();
    test_simultaneous();
    test_busy_drop();
    test_reset_mid_strobe();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
